// File: rtl/addsub_pkg.sv
// Shared types for the pipelined add/sub unit:
// opcode enum, flag bundle and flag bit positions.
package addsub_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } addsub_op_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } addsub_flags_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/addsub_stage.sv
// One CW-bit slice of the add/sub carry chain with its
// pipeline register and valid/advance handshake.
module addsub_stage
   import addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CW    = 16,
   parameter int K     = 0,
   parameter int TAG_W = 5
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic             i_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_s,
   input  logic             i_c,
   input  logic             i_sel,
   input  logic             i_sat,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_a,
   output logic [WIDTH-1:0] o_b,
   output logic [WIDTH-1:0] o_s,
   output logic             o_c,
   output logic             o_sel,
   output logic             o_sat,
   output logic [TAG_W-1:0] o_tag
);

   localparam int LO = K * CW;

   logic [CW:0]      add;
   logic [WIDTH-1:0] s_nxt;
   logic             load;

   assign add = {1'b0, i_a[LO +: CW]}
              + {1'b0, i_b[LO +: CW]}
              + {{CW{1'b0}}, i_c};

   always_comb begin
      s_nxt = i_s;
      s_nxt[LO +: CW] = add[CW-1:0];
   end

   // Load when empty or when the contents move on this cycle.
   assign o_ready = !o_valid || i_ready;
   assign load    = i_valid && o_ready;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_a     <= '0;
         o_b     <= '0;
         o_s     <= '0;
         o_c     <= 1'b0;
         o_sel   <= 1'b0;
         o_sat   <= 1'b0;
         o_tag   <= '0;
      end else begin
         if (o_ready)
            o_valid <= i_valid;
         if (load) begin
            o_a   <= i_a;
            o_b   <= i_b;
            o_s   <= s_nxt;
            o_c   <= add[CW];
            o_sel <= i_sel;
            o_sat <= i_sat;
            o_tag <= i_tag;
         end
      end
   end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/sub with valid/ready, NZCV flags and a tag.
// Define PIPELINED_ADDSUB_SAT_EN for signed saturation.
module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 5
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_sel,
   input  logic             i_sat,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_result,
   output logic [TAG_W-1:0] o_tag,
   output logic [3:0]       o_flags
);

   localparam int CW = WIDTH / STAGES;
   localparam int M  = WIDTH - 1;

   logic [STAGES:0] vld;
   logic [STAGES:0] rdy;
   logic [STAGES:0] cy;
   logic [STAGES:0] sel;
   logic [STAGES:0] sat;
   logic [WIDTH-1:0] a_w   [STAGES+1];
   logic [WIDTH-1:0] b_w   [STAGES+1];
   logic [WIDTH-1:0] s_w   [STAGES+1];
   logic [TAG_W-1:0] tag_w [STAGES+1];

   // Subtract as A + ~B + 1: invert B, carry-in 1.
   assign vld[0]   = i_valid;
   assign sel[0]   = i_sel;
   assign sat[0]   = i_sat;
   assign cy[0]    = (addsub_op_e'(i_sel) == OP_SUB);
   assign a_w[0]   = i_a;
   assign b_w[0]   = cy[0] ? ~i_b : i_b;
   assign s_w[0]   = '0;
   assign tag_w[0] = i_tag;

   assign rdy[STAGES] = i_ready;
   assign o_ready     = rdy[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      addsub_stage #(
         .WIDTH (WIDTH),
         .CW    (CW),
         .K     (k),
         .TAG_W (TAG_W)
      ) u_stage (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_valid (vld[k]),
         .o_ready (rdy[k]),
         .i_ready (rdy[k+1]),
         .i_a     (a_w[k]),
         .i_b     (b_w[k]),
         .i_s     (s_w[k]),
         .i_c     (cy[k]),
         .i_sel   (sel[k]),
         .i_sat   (sat[k]),
         .i_tag   (tag_w[k]),
         .o_valid (vld[k+1]),
         .o_a     (a_w[k+1]),
         .o_b     (b_w[k+1]),
         .o_s     (s_w[k+1]),
         .o_c     (cy[k+1]),
         .o_sel   (sel[k+1]),
         .o_sat   (sat[k+1]),
         .o_tag   (tag_w[k+1])
      );
   end

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] res;
   logic             ovf;
   logic             unused_bits;
   addsub_flags_t    fl;

   assign sum = s_w[STAGES];

   // Carry into the MSB recovered as sum ^ a ^ b at that bit.
   assign ovf = cy[STAGES] ^ sum[M]
              ^ a_w[STAGES][M] ^ b_w[STAGES][M];

`ifdef PIPELINED_ADDSUB_SAT_EN
   always_comb begin
      res = sum;
      if (sat[STAGES] && ovf)
         res = a_w[STAGES][M] ? {1'b1, {M{1'b0}}}
                              : {1'b0, {M{1'b1}}};
   end
`else
   assign res = sum;
`endif

   assign unused_bits = ^{a_w[STAGES][M-1:0],
                          b_w[STAGES][M-1:0],
                          sel[STAGES], sat[STAGES]};

   always_comb begin
      fl.n = res[M];
      fl.z = (res == '0);
      fl.c = cy[STAGES];
      fl.v = ovf;
   end

   assign o_valid  = vld[STAGES];
   assign o_result = o_valid ? res : '0;
   assign o_tag    = o_valid ? tag_w[STAGES] : '0;

   always_comb begin
      o_flags = '0;
      if (o_valid) begin
         o_flags[FLAG_N] = fl.n;
         o_flags[FLAG_Z] = fl.z;
         o_flags[FLAG_C] = fl.c;
         o_flags[FLAG_V] = fl.v;
      end
   end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub, WIDTH=32 STAGES=2.
module tb_pipelined_addsub;

   typedef struct packed {
      logic [31:0] r;
      logic [4:0]  t;
      logic [3:0]  f;
   } res_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sel;
      logic        sat;
      logic [4:0]  tag;
      res_t        want;
   } vec_t;

   logic        clk;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_a;
   logic [31:0] i_b;
   logic        i_sel;
   logic        i_sat;
   logic [4:0]  i_tag;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_result;
   logic [4:0]  o_tag;
   logic [3:0]  o_flags;

   int   tests = 0;
   int   fails = 0;
   res_t exp_q[$];

   pipelined_addsub #(
      .WIDTH  (32),
      .STAGES (2),
      .TAG_W  (5)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (i_rst_n),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_a      (i_a),
      .i_b      (i_b),
      .i_sel    (i_sel),
      .i_sat    (i_sat),
      .i_tag    (i_tag),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_result (o_result),
      .o_tag    (o_tag),
      .o_flags  (o_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic res_t model(logic [31:0] a, logic [31:0] b,
                                  logic sel, logic sat,
                                  logic [4:0] tag);
      logic [31:0] bb;
      logic [32:0] full;
      logic [31:0] r;
      logic        v;
      bb   = sel ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {32'd0, sel};
      r    = full[31:0];
      v    = (a[31] == bb[31]) && (r[31] != a[31]);
`ifdef PIPELINED_ADDSUB_SAT_EN
      if (sat && v)
         r = a[31] ? 32'h8000_0000 : 32'h7fff_ffff;
`else
      if (sat) r = r;
`endif
      return {r, tag, r[31], (r == 32'd0), full[32], v};
   endfunction

   // One clock: sample at negedge, score transfers, step edge.
   task automatic tick(output bit got, output bit acc,
                       output res_t obs, output res_t exp);
      @(negedge clk);
      got = 0; acc = 0; obs = '0; exp = '0;
      if (o_valid && i_ready) begin
         got = 1;
         obs = {o_result, o_tag, o_flags};
         if (exp_q.size() != 0) exp = exp_q.pop_front();
         else exp = ~obs;
      end
      if (i_valid && o_ready) begin
         acc = 1;
         exp_q.push_back(model(i_a, i_b, i_sel, i_sat, i_tag));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_rand();
      logic [31:0] edge_v [4];
      edge_v = '{32'h0, 32'hffff_ffff, 32'h7fff_ffff, 32'h8000_0000};
      i_a   = ($urandom_range(3) == 0) ? edge_v[$urandom_range(3)] : $urandom;
      i_b   = ($urandom_range(3) == 0) ? edge_v[$urandom_range(3)] : $urandom;
      i_sel = 1'($urandom_range(1));
      i_sat = 1'($urandom_range(1));
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      i_a = '0; i_b = '0; i_sel = 1'b0; i_sat = 1'b0; i_tag = '0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (o_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_valid: got %b want 0", o_valid);
      end
      tests++;
      if ({o_result, o_tag, o_flags} !== 41'd0) begin
         fails++;
         $display("FAIL reset_out: got %h/%h/%h want 0",
                  o_result, o_tag, o_flags);
      end
      i_rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (o_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready: got %b want 1", o_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      vec_t v [7];
      bit   got, acc;
      res_t obs, exp;
      v[0] = '{32'hffff_ffff, 32'h1, 1'b0, 1'b0, 5'd7,
               {32'h0, 5'd7, 4'b0110}};
      v[1] = '{32'h0000_ffff, 32'h1, 1'b0, 1'b0, 5'd9,
               {32'h0001_0000, 5'd9, 4'b0000}};
      v[2] = '{32'd5, 32'd7, 1'b1, 1'b0, 5'd3,
               {32'hffff_fffe, 5'd3, 4'b1000}};
`ifdef PIPELINED_ADDSUB_SAT_EN
      v[3] = '{32'h8000_0000, 32'h1, 1'b1, 1'b1, 5'd12,
               {32'h8000_0000, 5'd12, 4'b1011}};
      v[5] = '{32'h7fff_ffff, 32'h1, 1'b0, 1'b1, 5'd20,
               {32'h7fff_ffff, 5'd20, 4'b0001}};
`else
      v[3] = '{32'h8000_0000, 32'h1, 1'b1, 1'b1, 5'd12,
               {32'h7fff_ffff, 5'd12, 4'b0011}};
      v[5] = '{32'h7fff_ffff, 32'h1, 1'b0, 1'b1, 5'd20,
               {32'h8000_0000, 5'd20, 4'b1001}};
`endif
      v[4] = '{32'h8000_0000, 32'h1, 1'b1, 1'b0, 5'd13,
               {32'h7fff_ffff, 5'd13, 4'b0011}};
      v[6] = '{32'h0, 32'h0, 1'b1, 1'b0, 5'd31,
               {32'h0, 5'd31, 4'b0110}};
      i_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         i_valid = 1'b1; i_a = v[i].a; i_b = v[i].b;
         i_sel = v[i].sel; i_sat = v[i].sat; i_tag = v[i].tag;
         tick(got, acc, obs, exp);
         tests++;
         if (!acc) begin
            fails++;
            $display("FAIL dir%0d_accept: got %b want 1", i, acc);
         end
         i_valid = 1'b0; i_a = $urandom; i_b = $urandom;
         i_tag = 5'($urandom);
         tick(got, acc, obs, exp);
         tests++;
         if (got) begin
            fails++;
            $display("FAIL dir%0d_early: got valid want none", i);
         end
         tick(got, acc, obs, exp);
         tests++;
         if (!got) begin
            fails++;
            $display("FAIL dir%0d_latency: got none want valid", i);
         end else begin
            tests++;
            if (obs !== v[i].want) begin
               fails++;
               $display("FAIL dir%0d_const: got %h want %h",
                        i, obs, v[i].want);
            end
            tests++;
            if (obs !== exp) begin
               fails++;
               $display("FAIL dir%0d_model: got %h want %h",
                        i, obs, exp);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit         got, acc;
      res_t       obs, exp;
      int         idx;
      logic [4:0] seen[$];
      i_ready = 1'b0;
      idx = 0;
      for (int k = 0; k < 2; k++) begin
         i_valid = 1'b1; drive_rand(); i_tag = 5'(idx);
         tick(got, acc, obs, exp);
         tests++;
         if (!acc) begin
            fails++;
            $display("FAIL bp_fill%0d: got %b want 1", k, acc);
         end else idx++;
      end
      i_valid = 1'b1; drive_rand(); i_tag = 5'(idx);
      for (int k = 0; k < 3; k++) begin
         tick(got, acc, obs, exp);
         tests++;
         if (acc) begin
            fails++;
            $display("FAIL bp_oready%0d: got 1 want 0", k);
         end
         tests++;
         if (exp_q.size() == 0 ||
             {o_valid, o_result, o_tag, o_flags} !== {1'b1, exp_q[0]}) begin
            fails++;
            $display("FAIL bp_hold%0d: got %b/%h/%h/%h", k,
                     o_valid, o_result, o_tag, o_flags);
         end
      end
      i_ready = 1'b1;
      for (int cyc = 0; cyc < 30 && seen.size() < 4; cyc++) begin
         if (idx < 4) begin
            i_valid = 1'b1; drive_rand(); i_tag = 5'(idx);
         end else i_valid = 1'b0;
         tick(got, acc, obs, exp);
         if (acc) idx++;
         if (got) begin
            tests++;
            if (obs !== exp) begin
               fails++;
               $display("FAIL bp_data: got %h want %h", obs, exp);
            end
            seen.push_back(obs.t);
         end
      end
      i_valid = 1'b0;
      tests++;
      if (seen.size() != 4) begin
         fails++;
         $display("FAIL bp_count: got %0d want 4", seen.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            tests++;
            if (seen[k] !== 5'(k)) begin
               fails++;
               $display("FAIL bp_order%0d: got %0d want %0d",
                        k, seen[k], k);
            end
         end
      end
   endtask

   task automatic test_streaming();
      bit   got, acc, was_v;
      res_t obs, exp;
      int   issued, rcv, first, last;
      issued = 0; rcv = 0; first = -1; last = -1;
      i_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && rcv < 100; cyc++) begin
         if (issued < 100) begin
            i_valid = 1'b1; drive_rand(); i_tag = 5'($urandom);
         end else i_valid = 1'b0;
         was_v = i_valid;
         tick(got, acc, obs, exp);
         if (was_v) begin
            tests++;
            if (!acc) begin
               fails++;
               $display("FAIL st_ready%0d: got 0 want 1", cyc);
            end
         end
         if (acc) issued++;
         if (got) begin
            tests++;
            if (obs !== exp) begin
               fails++;
               $display("FAIL st_data%0d: got %h want %h", rcv, obs, exp);
            end
            if (rcv == 0) first = cyc;
            last = cyc;
            rcv++;
         end
      end
      i_valid = 1'b0;
      tests++;
      if (rcv != 100) begin
         fails++;
         $display("FAIL st_count: got %0d want 100", rcv);
      end
      tests++;
      if (first != 2 || last != first + 99) begin
         fails++;
         $display("FAIL st_rate: got first %0d last %0d want 2 101",
                  first, last);
      end
   endtask

   task automatic test_reset_midflight();
      bit   got, acc;
      res_t obs, exp;
      i_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         i_valid = 1'b1; drive_rand(); i_tag = 5'(k + 1);
         tick(got, acc, obs, exp);
      end
      i_rst_n = 1'b0; i_valid = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if (o_valid !== 1'b0) begin
         fails++;
         $display("FAIL rst_valid: got %b want 0", o_valid);
      end
      tests++;
      if ({o_result, o_tag, o_flags} !== 41'd0) begin
         fails++;
         $display("FAIL rst_out: got %h/%h/%h want 0",
                  o_result, o_tag, o_flags);
      end
      exp_q.delete();
      i_rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick(got, acc, obs, exp);
         tests++;
         if (got || o_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_stale%0d: got valid %b ready %b want 0 1",
                     k, got, o_ready);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_streaming();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
